// File: rtl/can_pkg.sv
// Shared definitions for the CAN error/overload frame generator.
package can_pkg;

  // Frame-generator states.
  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    ACT_FLAG     = 4'd1,
    PAS_FLAG     = 4'd2,
    WAIT_REC     = 4'd3,
    DELIM        = 4'd4,
    INTERMISSION = 4'd5,
    SUSPEND      = 4'd6,
    OVLD_FLAG    = 4'd7,
    BUS_OFF      = 4'd8
  } can_state_e;

  // Default field lengths in bit times.
  localparam int DEF_FLAG_LEN    = 6;
  localparam int DEF_DELIM_LEN   = 8;
  localparam int DEF_IFS_LEN     = 3;
  localparam int DEF_SUSPEND_LEN = 8;
  localparam int DEF_RECOV_SEQS  = 128;
  localparam int DEF_RECOV_BITS  = 11;

  // Width of the shared field-length down-counter.
  localparam int CNT_W = 8;

endpackage

// File: rtl/can_bit_counter.sv
// Loadable down-counter stepped by the bit sample strobe; stops at zero.
module can_bit_counter
  import can_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_point,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down one per sampled bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (sample_point && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/can_error_frame_gen.sv
// CAN error / overload frame generator with bus-off recovery sequencing.
module can_error_frame_gen
  import can_pkg::*;
#(
  parameter int FLAG_LEN    = DEF_FLAG_LEN,
  parameter int DELIM_LEN   = DEF_DELIM_LEN,
  parameter int IFS_LEN     = DEF_IFS_LEN,
  parameter int SUSPEND_LEN = DEF_SUSPEND_LEN,
  parameter int RECOV_SEQS  = DEF_RECOV_SEQS,
  parameter int RECOV_BITS  = DEF_RECOV_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic rx_bit,
  input  logic error_detected,
  input  logic tx_active,
  input  logic error_active,
  input  logic error_passive,
  input  logic bus_off,
  input  logic overload_request,
  input  logic eof_done,
  output logic tx_bit,
  output logic err_tx_en,
  output logic dominant_after_flag,
  output logic frame_done,
  output logic bus_idle,
  output logic recovery_done
);

  can_state_e state, state_n;
  logic       err_pend, err_pend_n, err_req, accepting, go_flag;
  logic       pas_prev, pas_prev_n, pas_last, pas_last_n;
  logic       dom_seen, dom_seen_n, susp_flag, susp_flag_n;
  logic       ovld_frame, ovld_frame_n;
  logic [1:0] ovld_cnt, ovld_cnt_n;
  logic [3:0] dom_cnt, dom_cnt_n, rec_bits, rec_bits_n;
  logic [6:0] rec_seqs, rec_seqs_n;
  logic       daf_n, frame_done_n, recov_n;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  // Counter preload for the field that starts when a state is entered.
  // DELIM preloads one short because the WAIT_REC exit sample is bit 1.
  function automatic logic [CNT_W-1:0] len_for(input can_state_e s);
    case (s)
      ACT_FLAG, PAS_FLAG, OVLD_FLAG: len_for = CNT_W'(FLAG_LEN - 1);
      DELIM:                         len_for = CNT_W'(DELIM_LEN - 2);
      INTERMISSION:                  len_for = CNT_W'(IFS_LEN - 1);
      SUSPEND:                       len_for = CNT_W'(SUSPEND_LEN - 1);
      default:                       len_for = '0;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  can_bit_counter #(.W(CNT_W)) u_len_cnt (
    .clk          (clk),
    .rst          (rst),
    .sample_point (sample_point),
    .load         (cnt_load),
    .load_val     (cnt_val),
    .zero         (cnt_zero)
  );

  assign accepting = (state == IDLE) || (state == INTERMISSION) || (state == SUSPEND);

  // State and bookkeeping registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      err_pend            <= 1'b0;
      pas_prev            <= 1'b0;
      pas_last            <= 1'b0;
      dom_seen            <= 1'b0;
      dom_cnt             <= '0;
      susp_flag           <= 1'b0;
      ovld_cnt            <= '0;
      ovld_frame          <= 1'b0;
      rec_bits            <= '0;
      rec_seqs            <= '0;
      dominant_after_flag <= 1'b0;
      frame_done          <= 1'b0;
      recovery_done       <= 1'b0;
    end else begin
      state               <= state_n;
      err_pend            <= err_pend_n;
      pas_prev            <= pas_prev_n;
      pas_last            <= pas_last_n;
      dom_seen            <= dom_seen_n;
      dom_cnt             <= dom_cnt_n;
      susp_flag           <= susp_flag_n;
      ovld_cnt            <= ovld_cnt_n;
      ovld_frame          <= ovld_frame_n;
      rec_bits            <= rec_bits_n;
      rec_seqs            <= rec_seqs_n;
      dominant_after_flag <= daf_n;
      frame_done          <= frame_done_n;
      recovery_done       <= recov_n;
    end
  end

  // Next-state logic: bus_off preempts everything, all else steps per sampled bit.
  always_comb begin
    state_n      = state;
    err_pend_n   = err_pend;
    pas_prev_n   = pas_prev;
    pas_last_n   = pas_last;
    dom_seen_n   = dom_seen;
    dom_cnt_n    = dom_cnt;
    susp_flag_n  = susp_flag;
    ovld_cnt_n   = ovld_cnt;
    ovld_frame_n = ovld_frame;
    rec_bits_n   = rec_bits;
    rec_seqs_n   = rec_seqs;
    daf_n        = 1'b0;
    frame_done_n = 1'b0;
    recov_n      = 1'b0;
    go_flag      = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    err_req      = err_pend | error_detected;
    if (bus_off && state != BUS_OFF) begin
      state_n    = BUS_OFF;
      err_pend_n = 1'b0;
      rec_bits_n = '0;
      rec_seqs_n = '0;
    end else if (!sample_point) begin
      // An error reported between strobes is held for the next bit boundary.
      if (error_detected && accepting) err_pend_n = 1'b1;
    end else begin
      err_pend_n = 1'b0;
      case (state)
        IDLE: begin
          if (err_req)       go_flag = 1'b1;
          else if (eof_done) state_n = INTERMISSION;
        end
        ACT_FLAG, OVLD_FLAG: begin
          if (cnt_zero) state_n = WAIT_REC;
        end
        PAS_FLAG: begin
          pas_prev_n = 1'b1;
          pas_last_n = rx_bit;
          if (pas_prev && rx_bit == pas_last) begin
            if (cnt_zero) state_n = WAIT_REC;
          end else begin
            // A new run of equal samples starts with this one.
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(FLAG_LEN - 2);
          end
        end
        WAIT_REC: begin
          if (rx_bit) begin
            state_n = DELIM;
          end else if (!dom_seen) begin
            dom_seen_n = 1'b1;
            dom_cnt_n  = '0;
            daf_n      = !tx_active && !ovld_frame;
          end else if (sat_inc4(dom_cnt) == 4'd8) begin
            dom_cnt_n = '0;
            daf_n     = !ovld_frame;
          end else begin
            dom_cnt_n = sat_inc4(dom_cnt);
          end
        end
        DELIM: begin
          if (!rx_bit) begin
            go_flag = 1'b1;
          end else if (cnt_zero) begin
            frame_done_n = 1'b1;
            state_n      = INTERMISSION;
          end
        end
        INTERMISSION: begin
          if (err_req) begin
            go_flag = 1'b1;
          end else if (!cnt_zero) begin
            if ((!rx_bit || overload_request) && ovld_cnt < 2'd2) begin
              state_n      = OVLD_FLAG;
              ovld_cnt_n   = ovld_cnt + 2'd1;
              ovld_frame_n = 1'b1;
              dom_seen_n   = 1'b0;
            end
          end else if (!rx_bit) begin
            state_n = IDLE;
          end else begin
            state_n = susp_flag ? SUSPEND : IDLE;
          end
        end
        SUSPEND: begin
          if (err_req)                   go_flag = 1'b1;
          else if (!rx_bit || cnt_zero)  state_n = IDLE;
        end
        BUS_OFF: begin
          if (!rx_bit) begin
            rec_bits_n = '0;
          end else if (rec_bits == 4'(RECOV_BITS - 1)) begin
            rec_bits_n = '0;
            if (rec_seqs == 7'(RECOV_SEQS - 1)) begin
              rec_seqs_n = '0;
              recov_n    = 1'b1;
              state_n    = IDLE;
            end else begin
              rec_seqs_n = rec_seqs + 7'd1;
            end
          end else begin
            rec_bits_n = rec_bits + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (go_flag) begin
      state_n      = error_active ? ACT_FLAG : PAS_FLAG;
      susp_flag_n  = error_passive && tx_active;
      dom_seen_n   = 1'b0;
      pas_prev_n   = 1'b0;
      ovld_cnt_n   = '0;
      ovld_frame_n = 1'b0;
    end
    if (state_n == IDLE && state != IDLE) begin
      ovld_cnt_n  = '0;
      susp_flag_n = 1'b0;
    end
    if (state_n != state) begin
      cnt_load = 1'b1;
      cnt_val  = len_for(state_n);
    end
  end

  assign tx_bit    = !(state == ACT_FLAG || state == OVLD_FLAG);
  assign err_tx_en = !(state == IDLE || state == BUS_OFF);
  assign bus_idle  = (state == IDLE);

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Randomized and directed scoreboard bench for can_error_frame_gen.
module tb_can_error_frame_gen;

  localparam int FLAG_LEN    = 6;
  localparam int DELIM_LEN   = 8;
  localparam int IFS_LEN     = 3;
  localparam int SUSPEND_LEN = 8;
  localparam int RECOV_SEQS  = 128;
  localparam int RECOV_BITS  = 11;

  localparam int M_IDLE = 0, M_ACT = 1, M_PAS = 2, M_WAIT = 3, M_DELIM = 4,
                 M_INT = 5, M_SUSP = 6, M_OVL = 7, M_BOFF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_point = 1'b0, rx_bit = 1'b1, error_detected = 1'b0, tx_active = 1'b0;
  logic error_active = 1'b1, error_passive = 1'b0, bus_off = 1'b0;
  logic overload_request = 1'b0, eof_done = 1'b0;
  logic tx_bit, err_tx_en, dominant_after_flag, frame_done, bus_idle, recovery_done;

  int n_cmp = 0;
  int n_bad = 0;
  int nbit  = 0;
  logic [5:0] exp_q[$];

  // Reference model state: phase, bits elapsed in phase, history and tallies.
  int m_ph = M_IDLE, m_nb = 0, m_dom = 0, m_ovl_n = 0, m_rrun = 0, m_rseq = 0;
  bit m_ovl = 0, m_susp = 0;
  bit m_hist[$];

  can_error_frame_gen #(
    .FLAG_LEN(FLAG_LEN), .DELIM_LEN(DELIM_LEN), .IFS_LEN(IFS_LEN),
    .SUSPEND_LEN(SUSPEND_LEN), .RECOV_SEQS(RECOV_SEQS), .RECOV_BITS(RECOV_BITS)
  ) dut (
    .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
    .error_detected(error_detected), .tx_active(tx_active),
    .error_active(error_active), .error_passive(error_passive), .bus_off(bus_off),
    .overload_request(overload_request), .eof_done(eof_done),
    .tx_bit(tx_bit), .err_tx_en(err_tx_en), .dominant_after_flag(dominant_after_flag),
    .frame_done(frame_done), .bus_idle(bus_idle), .recovery_done(recovery_done)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string nm, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic m_reset();
    m_ph = M_IDLE; m_nb = 0; m_dom = 0; m_ovl_n = 0; m_rrun = 0; m_rseq = 0;
    m_ovl = 0; m_susp = 0; m_hist.delete();
  endtask

  task automatic m_goto(input int p);
    m_ph = p; m_nb = 0; m_dom = 0;
    if (p == M_IDLE) begin m_ovl_n = 0; m_susp = 0; end
  endtask

  task automatic m_start_flag();
    m_goto(error_active ? M_ACT : M_PAS);
    m_susp = error_passive && tx_active;
    m_ovl_n = 0; m_ovl = 0; m_hist.delete();
  endtask

  // One bit of protocol behaviour; pushes the response expected after this sample.
  task automatic model_bit(input bit r, input bit e, input bit o, input bit f, input bit b);
    bit daf, fd, rd, same;
    daf = 0; fd = 0; rd = 0;
    if (b && m_ph != M_BOFF) begin
      m_goto(M_BOFF); m_rrun = 0; m_rseq = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (e) m_start_flag(); else if (f) m_goto(M_INT);
        M_ACT, M_OVL: begin m_nb++; if (m_nb == FLAG_LEN) m_goto(M_WAIT); end
        M_PAS: begin
          m_hist.push_back(r);
          if (m_hist.size() >= FLAG_LEN) begin
            same = 1;
            for (int k = 1; k < FLAG_LEN; k++)
              if (m_hist[m_hist.size() - 1 - k] != r) same = 0;
            if (same) m_goto(M_WAIT);
          end
        end
        M_WAIT: begin
          if (r) begin m_goto(M_DELIM); m_nb = 1; end
          else begin
            m_dom++;
            if (m_dom == 1) daf = !tx_active && !m_ovl;
            else if ((m_dom - 1) % 8 == 0) daf = !m_ovl;
          end
        end
        M_DELIM: begin
          if (!r) m_start_flag();
          else begin m_nb++; if (m_nb == DELIM_LEN) begin fd = 1; m_goto(M_INT); end end
        end
        M_INT: begin
          if (e) m_start_flag();
          else begin
            m_nb++;
            if (m_nb < IFS_LEN) begin
              if ((!r || o) && m_ovl_n < 2) begin m_goto(M_OVL); m_ovl_n++; m_ovl = 1; end
            end else if (!r) m_goto(M_IDLE);
            else m_goto(m_susp ? M_SUSP : M_IDLE);
          end
        end
        M_SUSP: begin
          if (e) m_start_flag();
          else begin m_nb++; if (!r || m_nb == SUSPEND_LEN) m_goto(M_IDLE); end
        end
        M_BOFF: begin
          if (!r) m_rrun = 0;
          else begin
            m_rrun++;
            if (m_rrun == RECOV_BITS) begin
              m_rrun = 0; m_rseq++;
              if (m_rseq == RECOV_SEQS) begin rd = 1; m_goto(M_IDLE); end
            end
          end
        end
        default: ;
      endcase
    end
    exp_q.push_back({(m_ph != M_ACT && m_ph != M_OVL), (m_ph != M_IDLE && m_ph != M_BOFF),
                     (m_ph == M_IDLE), daf, fd, rd});
  endtask

  // Drive one bit time (4 clocks) with a single sample strobe.
  task automatic send_bit(input bit r, input bit e, input bit o, input bit f, input bit b);
    @(negedge clk);
    rx_bit = r; error_detected = e; overload_request = o; eof_done = f; bus_off = b;
    sample_point = 1'b1;
    nbit++;
    model_bit(r, e, o, f, b);
    @(negedge clk);
    sample_point = 1'b0; error_detected = 1'b0; overload_request = 1'b0;
    eof_done = 1'b0; bus_off = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_n(input int n, input bit r);
    repeat (n) send_bit(r, 0, 0, 0, 0);
  endtask

  // Monitor: every strobe edge pops one expected response; other edges must show no pulses.
  initial begin : monitor
    logic [5:0] got, want;
    forever begin
      @(posedge clk);
      if (sample_point) begin
        #1;
        got = {tx_bit, err_tx_en, bus_idle, dominant_after_flag, frame_done, recovery_done};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bit_rsp bit=%0d got=%b want=queued_entry", nbit, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL bit_rsp bit=%0d {tx,en,idle,daf,fd,rd} got=%b want=%b", nbit, got, want);
          end
        end
      end else begin
        #1;
        n_cmp++;
        if ({dominant_after_flag, frame_done, recovery_done} !== 3'b000) begin
          n_bad++;
          $display("FAIL pulse_quiet bit=%0d got=%b want=000", nbit,
                   {dominant_after_flag, frame_done, recovery_done});
        end
      end
    end
  end

  initial begin : stim
    int guard;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_bit", tx_bit, 1'b1);
    chk("reset_err_tx_en", err_tx_en, 1'b0);
    chk("reset_bus_idle", bus_idle, 1'b1);
    chk("reset_pulses", dominant_after_flag | frame_done | recovery_done, 1'b0);
    rst = 1'b1;
    m_reset();

    // Active receiver: flag, two extra dominant bits, delimiter, intermission.
    error_active = 1; error_passive = 0; tx_active = 0;
    send_bit(1, 1, 0, 0, 0); send_n(6, 0); send_n(2, 0); send_n(8, 1); send_n(3, 1);

    // Passive flag exits on a run of equal samples.
    error_active = 0; error_passive = 1; tx_active = 0;
    send_bit(1, 1, 0, 0, 0); send_n(2, 1); send_n(6, 0); send_n(1, 0); send_n(8, 1); send_n(3, 1);

    // Passive transmitter: full frame followed by suspend transmission.
    tx_active = 1;
    send_bit(1, 1, 0, 0, 0); send_n(6, 1); send_n(8, 1); send_n(3, 1); send_n(8, 1); send_n(2, 1);

    // Long dominant tail: repeated pulses every 8 dominant bits after the first.
    error_active = 1; error_passive = 0; tx_active = 0;
    send_bit(1, 1, 0, 0, 0); send_n(6, 0); send_n(25, 0); send_n(8, 1); send_n(3, 1);

    // Overload frames: two accepted, third ignored.
    send_bit(1, 1, 0, 0, 0); send_n(6, 0); send_n(8, 1);
    for (int k = 0; k < 3; k++) begin
      send_bit(1, 0, 0, 0, 0); send_bit(1, 0, 1, 0, 0);
      if (k < 2) begin send_n(6, 0); send_n(8, 1); end
    end
    send_n(2, 1);

    // Normal end of frame into intermission, overload from dominant bit 1.
    send_bit(1, 0, 0, 1, 0); send_bit(0, 0, 0, 0, 0); send_n(6, 0); send_n(8, 1); send_n(3, 1);

    // Form error in delimiter restarts the flag.
    send_bit(1, 1, 0, 0, 0); send_n(6, 0); send_n(3, 1); send_bit(0, 0, 0, 0, 0);
    send_n(6, 0); send_n(8, 1); send_n(3, 1);

    // Bus-off mid flag, recovery with a dominant bit inside sequence 5.
    tx_active = 1;
    send_bit(1, 1, 0, 0, 0); send_n(3, 0); send_bit(0, 1, 0, 0, 1);
    send_n(4 * RECOV_BITS, 1); send_n(5, 1); send_n(1, 0);
    guard = 0;
    while (m_ph == M_BOFF && guard < 2000) begin send_n(1, 1); guard++; end
    send_n(2, 1);

    // Reset asserted in the delimiter releases the bus at once.
    error_active = 1; error_passive = 0; tx_active = 0;
    send_bit(1, 1, 0, 0, 0); send_n(6, 0); send_n(3, 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_delim_tx_bit", tx_bit, 1'b1);
    chk("rst_delim_err_tx_en", err_tx_en, 1'b0);
    chk("rst_delim_bus_idle", bus_idle, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    m_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      error_active  = ($urandom_range(0, 3) != 0);
      error_passive = !error_active;
      tx_active     = $urandom_range(0, 1);
      send_bit($urandom_range(0, 99) < 85, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 1'b0);
    end

    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_error_frame_gen.md
CAN_ERROR_FRAME_GEN -- requirements
Module: can_error_frame_gen

Interface
REQ-001 SHALL have parameters: FLAG_LEN, default 6, error/overload flag length in bits; DELIM_LEN, default 8, delimiter length in recessive bits; IFS_LEN, default 3, intermission bits; SUSPEND_LEN, default 8, suspend-transmission bits; RECOV_SEQS, default 128, bus-off recovery sequence count; RECOV_BITS, default 11, recessive bits per recovery sequence.
REQ-002 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: sample_point  in  1  one-cycle bit sample strobe; rx_bit  in  1  sampled bus level (1 = recessive).
REQ-004 SHALL have ports: error_detected  in  1  pulse, any bit/stuff/form/ack/CRC error; tx_active  in  1  node is transmitter.
REQ-005 SHALL have ports: error_active, error_passive, bus_off  in  1 each  node error state; overload_request  in  1  overload condition; eof_done  in  1  pulse at end of EOF field.
REQ-006 SHALL have ports: tx_bit  out  1  bit driven to bus; err_tx_en  out  1  this block owns tx_bit; dominant_after_flag  out  1  pulse; frame_done  out  1  pulse; bus_idle  out  1; recovery_done  out  1  pulse.

Function
REQ-007 SHALL implement states IDLE, ACT_FLAG, PAS_FLAG, WAIT_REC, DELIM, INTERMISSION, SUSPEND, OVLD_FLAG, BUS_OFF; all bit-level transitions and counters advance only on sample_point cycles.
REQ-008 SHALL, from IDLE, INTERMISSION or SUSPEND, on error_detected, enter ACT_FLAG if error_active, else PAS_FLAG; flag starts at the next bit (first tx_bit change one clk after the sample_point following the error).
REQ-009 SHALL drive tx_bit=0 for FLAG_LEN bits in ACT_FLAG and tx_bit=1 in PAS_FLAG; err_tx_en=1 in every state except IDLE and BUS_OFF.
REQ-010 SHALL leave PAS_FLAG only after FLAG_LEN consecutive equal rx_bit samples (either polarity) observed while in it; ACT_FLAG leaves after exactly FLAG_LEN bits.
REQ-011 SHALL in WAIT_REC drive recessive and stay until rx_bit=1 is sampled; that sample counts as delimiter bit 1.
REQ-012 SHALL, when not tx_active, pulse dominant_after_flag for one clk on the first rx_bit=0 sample in WAIT_REC, only once per error frame.
REQ-013 SHALL in WAIT_REC, per 8 consecutive dominant samples after the first, pulse dominant_after_flag again (tolerance counter, 4-bit saturating).
REQ-014 SHALL in DELIM count DELIM_LEN total recessive bits, then pulse frame_done and enter INTERMISSION; rx_bit=0 in DELIM is a form error: restart flag per REQ-008.
REQ-015 SHALL in INTERMISSION count IFS_LEN bits; rx_bit=0 or overload_request in bits 1-2 enters OVLD_FLAG; dominant in bit 3 returns to IDLE (SOF).
REQ-016 SHALL after INTERMISSION enter SUSPEND if error_passive and tx_active were both true at flag start, else IDLE; SUSPEND drives recessive SUSPEND_LEN bits; rx_bit=0 in SUSPEND returns to IDLE.
REQ-017 SHALL drive FLAG_LEN dominant bits in OVLD_FLAG, then WAIT_REC/DELIM as for error frames without dominant_after_flag pulses; at most 2 consecutive overload frames, third request ignored.
REQ-018 SHALL enter BUS_OFF from any state when bus_off=1 (highest priority over error_detected); tx_bit=1, err_tx_en=0.
REQ-019 SHALL in BUS_OFF count RECOV_BITS consecutive recessive samples as one sequence (7-bit sequence counter, 4-bit bit counter); a dominant sample clears only the bit counter; after RECOV_SEQS sequences pulse recovery_done one clk and enter IDLE.
REQ-020 SHALL assert bus_idle only in IDLE; eof_done in IDLE enters INTERMISSION (normal end of frame).
REQ-021 SHALL ignore error_detected while in a flag state; error_detected coincident with bus_off is dropped.

Reset
REQ-022 SHALL on rst=0 force state IDLE, tx_bit=1, err_tx_en=0, all pulses 0, bus_idle=1, all counters 0; reset mid-flag releases bus to recessive immediately.

Structure
REQ-023 SHALL place the state enum and default length constants in shared package can_pkg.
REQ-024 SHALL instantiate one sub-module can_bit_counter (loadable down-counter with sample_point enable and zero flag) for flag/delimiter/intermission/suspend lengths.

Verification
REQ-025 Error-active receiver, error_detected, then rx 6x0, 2x0, 8x1 -> tx_bit 0 for 6 bits, one dominant_after_flag pulse, frame_done after 8th recessive.
REQ-026 Error-passive, rx sequence 1,1,0,0,0,0,0,0 -> PAS_FLAG exits after 6th equal dominant sample, tx_bit stays 1 throughout.
REQ-027 Passive transmitter error frame completes -> 3 intermission bits then 8 SUSPEND bits recessive, then bus_idle=1.
REQ-028 overload_request in intermission bit 2 -> 6 dominant bits, 8-bit delimiter; third consecutive request -> no flag.
REQ-029 bus_off asserted mid-ACT_FLAG -> tx_bit=1 next clk; 128x11 recessive samples with a dominant inserted at sequence 5 -> recovery_done after exactly 1408 further counted recessive bits.
REQ-030 rst low during DELIM -> tx_bit=1, err_tx_en=0, bus_idle=1 within same cycle.
